// File: rtl/mul23_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul23_pkg
// Description : Shared widths, MISR taps and serializer state encoding for the
//               mul23 result path.
// Revision    : 1.0 - initial release
// ============================================================================
package mul23_pkg;

    localparam int RES_W = 46;
    localparam logic [RES_W-1:0] MISR_POLY_DEFAULT = 46'h21;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/misr.sv
`default_nettype none
// ============================================================================
// Module      : misr
// Description : Multiple-input signature register; folds din into sig when en.
// Revision    : 1.0 - initial release
// ============================================================================
module misr
    import mul23_pkg::*;
#(
    parameter int               WIDTH = RES_W,
    parameter logic [WIDTH-1:0] POLY  = MISR_POLY_DEFAULT,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] r_sig;
    logic [WIDTH-1:0] w_sig_next;

    // MSB leaves the register and, when set, injects the feedback taps.
    always_comb begin
        w_sig_next = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= SEED;
        end else if (en) begin
            r_sig <= w_sig_next;
        end
    end

    assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/product_serializer.sv
`default_nettype none
// ============================================================================
// Module      : product_serializer
// Description : Captures a compressor result word, shifts it out LSB-first with
//               backpressure, and compacts every captured word into a MISR.
// Revision    : 1.0 - initial release
// ============================================================================
module product_serializer
    import mul23_pkg::*;
#(
    parameter int               WIDTH = RES_W,
    parameter logic [WIDTH-1:0] POLY  = MISR_POLY_DEFAULT,
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dst,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sout_last,
    output logic [WIDTH-1:0] sig,
    output logic [CNT_W-1:0] vec_count
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [BIT_W-1:0] r_bitcnt;
    logic [CNT_W-1:0] r_vec_count;
    logic             w_capture;
    logic             w_is_last;

    assign w_capture = (r_state == IDLE) && load_valid;
    assign w_is_last = (r_bitcnt == C_LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            r_vec_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_valid) begin
                        r_shreg     <= dst;
                        r_bitcnt    <= '0;
                        r_vec_count <= r_vec_count + CNT_W'(1);
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sout_ready) begin
                        if (w_is_last) begin
                            // Cleared so sout idles low between words.
                            r_shreg <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_shreg  <= r_shreg >> 1;
                            r_bitcnt <= r_bitcnt + BIT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign load_ready = (r_state == IDLE);
    assign sout       = r_shreg[0];
    assign sout_valid = (r_state == SHIFT);
    assign sout_last  = (r_state == SHIFT) && w_is_last;
    assign vec_count  = r_vec_count;

    misr #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .en  (w_capture),
        .din (dst),
        .sig (sig)
    );

endmodule
`default_nettype wire

// File: tb/tb_product_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_product_serializer
// Description : Table-driven scoreboard bench for product_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_product_serializer;

    localparam int W = 46;

    typedef struct {
        logic b;
        logic last;
    } bit_t;

    typedef struct {
        logic          do_rst;
        logic [W-1:0]  dst;
        int            mode;     // 0 always ready, 1 ready 1-0-0 pattern, 2 random
        logic          intrude;  // pulse load_valid while shifting
        logic [W-1:0]  exp_sig;
        logic [15:0]   exp_cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  dst = '0;
    logic          load_valid = 1'b0;
    logic          sout_ready = 1'b0;
    logic          load_ready, sout, sout_valid, sout_last;
    logic [W-1:0]  sig;
    logic [15:0]   vec_count;
    logic          s_load_ready, s_sout, s_sout_valid, s_sout_last;
    logic [W-1:0]  s_sig;
    logic [1:0]    s_vec_count;

    bit_t q[$];
    vec_t v[7];
    int   n_checks = 0;
    int   n_fail   = 0;

    product_serializer dut (
        .clk(clk), .rst(rst), .dst(dst), .load_valid(load_valid),
        .load_ready(load_ready), .sout(sout), .sout_valid(sout_valid),
        .sout_ready(sout_ready), .sout_last(sout_last), .sig(sig),
        .vec_count(vec_count)
    );

    product_serializer #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .dst(dst), .load_valid(load_valid),
        .load_ready(s_load_ready), .sout(s_sout), .sout_valid(s_sout_valid),
        .sout_ready(sout_ready), .sout_last(s_sout_last), .sig(s_sig),
        .vec_count(s_vec_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Serial-side monitor: pops the scoreboard on every accepted bit.
    initial begin
        bit_t e;
        logic held_pending = 1'b0;
        logic held_bit = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_pending = 1'b0;
            end else begin
                if (held_pending && sout_valid)
                    check("stall_hold", 64'(sout), 64'(held_bit));
                held_pending = 1'b0;
                if (sout_valid && sout_ready) begin
                    if (q.size() == 0) begin
                        check("extra_bit", 64'(1), 64'(0));
                    end else begin
                        e = q.pop_front();
                        check("sout_bit", 64'(sout), 64'(e.b));
                        check("sout_last", 64'(sout_last), 64'(e.last));
                    end
                end else if (sout_valid) begin
                    held_pending = 1'b1;
                    held_bit     = sout;
                end else begin
                    check("idle_last", 64'(sout_last), 64'(0));
                end
            end
        end
    end

    task automatic reset_dut();
        rst = 1'b1;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic apply_vec(input vec_t t);
        int cyc;
        if (t.do_rst) reset_dut();
        sout_ready = (t.mode == 0);
        check("ready_before_load", 64'(load_ready), 64'(1));
        for (int i = 0; i < W; i++) q.push_back('{b: t.dst[i], last: (i == W - 1)});
        dst        = t.dst;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        dst        = {$urandom, $urandom};
        check("first_bit_valid", 64'(sout_valid), 64'(1));
        check("ready_low_in_shift", 64'(load_ready), 64'(0));
        cyc = 0;
        while (q.size() > 0 && cyc < 400) begin
            case (t.mode)
                0:       sout_ready = 1'b1;
                1:       sout_ready = (cyc % 3 == 0);
                default: sout_ready = 1'($urandom_range(0, 1));
            endcase
            if (t.intrude && cyc < 20) begin
                load_valid = 1'b1;
                dst        = 46'h15;
                check("ready_low_intrude", 64'(load_ready), 64'(0));
            end else begin
                load_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        load_valid = 1'b0;
        check("word_done_in_budget", 64'(q.size()), 64'(0));
        check("idle_valid", 64'(sout_valid), 64'(0));
        check("idle_ready", 64'(load_ready), 64'(1));
        check("idle_sout", 64'(sout), 64'(0));
        check("sig", 64'(sig), 64'(t.exp_sig));
        check("vec_count", 64'(vec_count), 64'(t.exp_cnt));
        check("vec_count_w2", 64'(s_vec_count), 64'(t.exp_cnt[1:0]));
    endtask

    initial begin
        v[0] = '{1'b1, 46'h1,              0, 1'b0, 46'h1,              16'd1};
        v[1] = '{1'b1, 46'h2000_0000_0000, 0, 1'b0, 46'h2000_0000_0000, 16'd1};
        v[2] = '{1'b0, 46'h0,              0, 1'b0, 46'h21,             16'd2};
        v[3] = '{1'b0, 46'h3FFF_FFFF_FFFF, 1, 1'b0, 46'h3FFF_FFFF_FFBD, 16'd3};
        v[4] = '{1'b0, 46'h15,             2, 1'b0, 46'h3FFF_FFFF_FF4E, 16'd4};
        v[5] = '{1'b0, 46'h2AAA_AAAA_AAAA, 0, 1'b1, 46'h1555_5555_5417, 16'd5};
        v[6] = '{1'b0, 46'h1234_5678_9ABC, 1, 1'b0, 46'h1234_5678_9ABC, 16'd1};

        #12;
        check("rst_load_ready", 64'(load_ready), 64'(1));
        check("rst_sout", 64'(sout), 64'(0));
        check("rst_sout_valid", 64'(sout_valid), 64'(0));
        check("rst_sout_last", 64'(sout_last), 64'(0));
        check("rst_sig", 64'(sig), 64'(0));
        check("rst_vec_count", 64'(vec_count), 64'(0));

        for (int i = 0; i < 6; i++) apply_vec(v[i]);

        // Reset in the middle of a word: partial word must vanish.
        sout_ready = 1'b1;
        for (int i = 0; i < W; i++) q.push_back('{b: 1'b1, last: (i == W - 1)});
        dst        = '1;
        load_valid = 1'b1;
        @(posedge clk);
        #1 load_valid = 1'b0;
        for (int c = 0; c < 100 && q.size() > W - 10; c++) begin
            @(posedge clk);
            #1;
        end
        check("bits_before_reset", 64'(q.size()), 64'(W - 10));
        #1 rst = 1'b1;
        #1;
        q.delete();
        check("midrst_valid", 64'(sout_valid), 64'(0));
        check("midrst_ready", 64'(load_ready), 64'(1));
        check("midrst_sout", 64'(sout), 64'(0));
        check("midrst_sig", 64'(sig), 64'(0));
        check("midrst_vec_count", 64'(vec_count), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        apply_vec(v[6]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/product_serializer.md
Name: product_serializer

Overview:
- Downstream stage of the mul23 compression tree.
- Captures the 46-column compressor result (one bit per column, column 0 = LSB) with a valid/ready handshake.
- Shifts the captured word out LSB-first on a single serial pin with backpressure.
- Folds every captured word into a multiple-input signature register (MISR), so long test runs can be checked from one final value.

Parameters:
- WIDTH, 46, number of result columns (2 x 23 operand bits); must be >= 2.
- POLY, 46'h21, MISR feedback taps, XORed in when the signature MSB shifts out.
- SEED, 46'h0, MISR value after reset.
- CNT_W, 16, width of the captured-word counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- dst  in  WIDTH  compressor result; bit i = column i (dst0..dst45 concatenated at the instantiation site).
- load_valid  in  1  dst holds a result to capture.
- load_ready  out  1  block can capture this cycle.
- sout  out  1  current serial bit.
- sout_valid  out  1  sout carries a result bit.
- sout_ready  in  1  consumer accepts sout this cycle.
- sout_last  out  1  sout is column WIDTH-1.
- sig  out  WIDTH  current MISR signature.
- vec_count  out  CNT_W  number of words captured since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset state (async assert, any state): state=IDLE, shreg=0, bitcnt=0, sig=SEED, vec_count=0.
  - Outputs under reset: load_ready=1, sout=0, sout_valid=0, sout_last=0.
  - Release is clean on the next clk edge.
- State IDLE:
  - load_ready=1, sout_valid=0.
  - On load_valid=1: shreg<=dst, bitcnt<=0, vec_count<=vec_count+1, MISR update, go to SHIFT.
- State SHIFT:
  - load_ready=0; load_valid is ignored, with no capture and no MISR update.
  - sout=shreg[0], sout_valid=1, sout_last=(bitcnt==WIDTH-1).
  - On sout_ready=1 and not last: shreg<=shreg>>1, bitcnt<=bitcnt+1.
  - On sout_ready=1 and last: go to IDLE, shreg<=0.
  - On sout_ready=0: hold sout, bitcnt and shreg unchanged for any number of stall cycles.
- Latency and throughput:
  - First serial bit is valid the cycle after capture.
  - Unstalled transfer takes WIDTH cycles in SHIFT, plus 1 IDLE cycle before the next capture.
  - One word per WIDTH+1 cycles minimum; back-to-back capture in the same cycle as the last bit is not supported.
- MISR update, applied only on capture:
  - sig <= {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ dst.
  - Width is exactly WIDTH; the MSB is dropped after feedback.
- vec_count: wraps from all-ones to 0 with no flag.
- Boundary cases:
  - sout_ready held high in IDLE: no effect.
  - load_valid and sout_ready both high in SHIFT: only the shift occurs.
  - Reset during SHIFT: the partial word is discarded and sig returns to SEED.
- All outputs are registered or decoded only from state/shreg/bitcnt. No combinational path from any input to any output.

Decomposition:
- Package mul23_pkg:
  - RES_W=46 (=2*23).
  - MISR_POLY_DEFAULT=46'h21.
  - State enum {IDLE, SHIFT}.
- Sub-module misr: parameters WIDTH/POLY/SEED; ports clk, rst, en, din, sig. Instantiated once.
- Serializer FSM, shreg and bitcnt (width $clog2(WIDTH)) stay in product_serializer.

Test Plan:
- Reset then dst=46'h1 loaded, sout_ready=1 constantly -> sout=1 in cycle 1, then 45 zeros; sout_last high only on the 46th bit; sig=46'h1; vec_count=1.
- Load dst=46'h2000_0000_0000 (bit45), then dst=0 -> second sig = 46'h21 (POLY); vec_count=2; serial stream of the first word is 45 zeros then 1.
- Load dst=46'h3FFF_FFFF_FFFF, sout_ready toggled 1,0,0,1,... -> each bit held while ready=0; exactly 46 accepted bits, all 1; no bit repeated or lost.
- Pulse load_valid with dst=46'h15 during SHIFT -> load_ready=0; no capture; sig and vec_count unchanged; the current word completes intact.
- Assert rst after 10 bits of a word -> next cycle state IDLE, sout_valid=0, sig=SEED, vec_count=0; a new load after release serializes correctly.
- Preset counter path with CNT_W=2, capture 5 words -> vec_count sequence 1,2,3,0,1.
